// File: rtl/bus_arbiter_custom_pkg.sv
// Shared types and constants for the two-master bus arbiter.
// Grants are decoded straight from the arbiter state register.
package bus_arbiter_custom_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } arb_state_t;

  typedef logic master_t;

  localparam master_t M0 = 1'b0;
  localparam master_t M1 = 1'b1;

  localparam logic EN     = 1'b1;
  localparam logic DIS_EN = 1'b0;

endpackage

// File: rtl/bus_arbiter_custom.sv
// Two-master round-robin bus arbiter with hold-limit preemption.
// Grant changes wait until no bus access is outstanding.
module bus_arbiter_custom
  import bus_arbiter_custom_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req_m0,
  input  logic req_m1,
  input  logic addr_strobe_i,
  input  logic rdy_i,
  output logic grant_m0,
  output logic grant_m1,
  output logic busy_o
);

  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam bit PREEMPT_EN = (MAX_HOLD != 0);

  arb_state_t    state_q, state_d;
  master_t       last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          busy_q, busy_d;
  logic          switch_ok;
  logic          hold_full;
  logic          other_req;

  always_comb begin
    // A strobe alongside rdy starts the next access, so busy stays set.
    busy_d    = addr_strobe_i | (busy_q & ~rdy_i);
    switch_ok = ~busy_d;
    hold_full = PREEMPT_EN && (hold_q == HOLD_MAX);
    state_d   = state_q;

    case (state_q)
      IDLE: begin
        if (switch_ok) begin
          if (req_m0 && req_m1) begin
            state_d = (last_q == M0) ? OWN_M1 : OWN_M0;
          end else if (req_m0) begin
            state_d = OWN_M0;
          end else if (req_m1) begin
            state_d = OWN_M1;
          end
        end
      end
      OWN_M0: begin
        if (switch_ok) begin
          if (!req_m0) begin
            state_d = req_m1 ? OWN_M1 : IDLE;
          end else if (req_m1 && hold_full) begin
            state_d = OWN_M1;
          end
        end
      end
      OWN_M1: begin
        if (switch_ok) begin
          if (!req_m1) begin
            state_d = req_m0 ? OWN_M0 : IDLE;
          end else if (req_m0 && hold_full) begin
            state_d = OWN_M0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    last_d = last_q;
    if (state_d != state_q) begin
      if (state_d == OWN_M0) begin
        last_d = M0;
      end else if (state_d == OWN_M1) begin
        last_d = M1;
      end
    end

    other_req = (state_q == OWN_M0) ? req_m1 :
                (state_q == OWN_M1) ? req_m0 : 1'b0;

    hold_d = hold_q;
    if (state_d != state_q) begin
      hold_d = '0;
    end else if (other_req && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= M1;
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_m0 = (state_q == OWN_M0) ? EN : DIS_EN;
  assign grant_m1 = (state_q == OWN_M1) ? EN : DIS_EN;
  assign busy_o   = busy_q;

endmodule
